// File: rtl/ale_frame_engine.sv
`default_nettype none
// ============================================================================
// Module : ale_frame_engine
// Brief  : Per-frame atmospheric light estimate, IIR-smoothed, with 1/A.
// Rev    : 1.0  initial release
// ============================================================================
module ale_frame_engine #(
  parameter int DATA_W       = 8,
  parameter int IMG_W        = 512,
  parameter int IMG_H        = 512,
  parameter int WIN_PIX      = 9,
  parameter int INV_W        = 16,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        input_valid,
  input  logic [WIN_PIX*3*DATA_W-1:0] input_window,
  output logic [DATA_W-1:0]           A_R,
  output logic [DATA_W-1:0]           A_G,
  output logic [DATA_W-1:0]           A_B,
  output logic [INV_W-1:0]            Inv_A_R,
  output logic [INV_W-1:0]            Inv_A_G,
  output logic [INV_W-1:0]            Inv_A_B,
  output logic                        A_valid,
  output logic                        ALE_done,
  output logic                        overrun
);

  localparam int c_frame_pix = IMG_W * IMG_H;
  localparam int c_cnt_w     = (c_frame_pix > 1) ? $clog2(c_frame_pix) : 1;
  localparam int c_step_w    = $clog2(INV_W + 1);

  // Channel index matches the pixel packing: [2]=R, [1]=G, [0]=B.
  typedef logic [2:0][DATA_W-1:0] rgb_t;
  typedef enum logic [1:0] {IDLE, SMOOTH, DIVIDE, PUBLISH} state_t;

  rgb_t               win_min;
  rgb_t               s1_min_q;
  logic               s1_valid_q;
  logic               s1_last_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               frame_end;

  always_comb begin
    win_min = '1;
    for (int k = 0; k < WIN_PIX; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (input_window[k*3*DATA_W + c*DATA_W +: DATA_W] < win_min[c])
          win_min[c] = input_window[k*3*DATA_W + c*DATA_W +: DATA_W];
      end
    end
  end

  assign frame_end = input_valid && (cnt_q == c_cnt_w'(c_frame_pix - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      s1_min_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= input_valid;
      s1_last_q  <= frame_end;
      if (input_valid) begin
        s1_min_q <= win_min;
        cnt_q    <= frame_end ? '0 : cnt_q + 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] s1_dark;
  rgb_t              cand_q;
  rgb_t              cand_d;
  logic [DATA_W-1:0] cand_dark_q;
  logic [DATA_W-1:0] cand_dark_d;
  logic              first_q;
  logic              take;
  logic              frame_done;

  always_comb begin
    s1_dark = s1_min_q[0];
    if (s1_min_q[1] < s1_dark) s1_dark = s1_min_q[1];
    if (s1_min_q[2] < s1_dark) s1_dark = s1_min_q[2];
  end

  // Strict compare: a later pixel with an equal dark value never displaces the held one.
  assign take        = s1_valid_q && (first_q || (s1_dark > cand_dark_q));
  assign cand_d      = take ? s1_min_q : cand_q;
  assign cand_dark_d = take ? s1_dark : cand_dark_q;
  assign frame_done  = s1_valid_q && s1_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q      <= '0;
      cand_dark_q <= '0;
      first_q     <= 1'b1;
    end else if (s1_valid_q) begin
      cand_q      <= cand_d;
      cand_dark_q <= cand_dark_d;
      first_q     <= s1_last_q;
    end
  end

  state_t                state_q;
  rgb_t                  frame_q;
  rgb_t                  a_new_q;
  rgb_t                  rem_q;
  logic [2:0][INV_W:0]   quo_q;
  logic [c_step_w-1:0]   step_q;
  rgb_t                  a_pub;
  rgb_t                  smooth_d;
  logic [2:0][DATA_W:0]  rem_sh;
  logic [2:0]            q_bit;
  logic [2:0][INV_W-1:0] inv_d;

  assign a_pub = {A_R, A_G, A_B};

  always_comb begin : smooth_div
    logic [DATA_W:0] diff;
    for (int c = 0; c < 3; c++) begin
      diff        = {1'b0, frame_q[c]} - {1'b0, a_pub[c]};
      smooth_d[c] = A_valid ? DATA_W'($signed({1'b0, a_pub[c]}) + ($signed(diff) >>> SMOOTH_SHIFT))
                            : frame_q[c];
      // Dividend 2^INV_W enters MSB first: a single 1 on the first step, zeros after.
      rem_sh[c]   = {rem_q[c], (step_q == '0)};
      q_bit[c]    = (rem_sh[c] >= {1'b0, a_new_q[c]});
      // Quotient bit INV_W is set only for A<=1 (including A=0), so it doubles as the saturation flag.
      inv_d[c]    = quo_q[c][INV_W] ? {INV_W{1'b1}} : quo_q[c][INV_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      a_new_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      A_R      <= '0;
      A_G      <= '0;
      A_B      <= '0;
      Inv_A_R  <= '0;
      Inv_A_G  <= '0;
      Inv_A_B  <= '0;
      A_valid  <= 1'b0;
      ALE_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      ALE_done <= 1'b0;
      if (frame_done && (state_q != IDLE))
        overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (frame_done) begin
            frame_q <= cand_d;
            state_q <= SMOOTH;
          end
        end
        SMOOTH: begin
          a_new_q <= smooth_d;
          rem_q   <= '0;
          quo_q   <= '0;
          step_q  <= '0;
          state_q <= DIVIDE;
        end
        DIVIDE: begin
          for (int c = 0; c < 3; c++) begin
            rem_q[c] <= q_bit[c] ? DATA_W'(rem_sh[c] - {1'b0, a_new_q[c]}) : DATA_W'(rem_sh[c]);
            quo_q[c] <= {quo_q[c][INV_W-1:0], q_bit[c]};
          end
          step_q <= step_q + 1'b1;
          if (step_q == c_step_w'(INV_W))
            state_q <= PUBLISH;
        end
        PUBLISH: begin
          A_R      <= a_new_q[2];
          A_G      <= a_new_q[1];
          A_B      <= a_new_q[0];
          Inv_A_R  <= inv_d[2];
          Inv_A_G  <= inv_d[1];
          Inv_A_B  <= inv_d[0];
          A_valid  <= 1'b1;
          ALE_done <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ale_frame_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_ale_frame_engine
// Brief  : Scoreboard bench for ale_frame_engine with a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ale_frame_engine;
  localparam int DW   = 8;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int WP   = 9;
  localparam int INVW = 16;
  localparam int SH   = 2;
  localparam int NPIX = IW * IH;
  localparam int BUSY = INVW + 4;
  localparam int WB   = WP * 3 * DW;
  localparam int SAT  = (1 << INVW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_valid;
  logic [WB-1:0]   input_window;
  logic [DW-1:0]   A_R, A_G, A_B;
  logic [INVW-1:0] Inv_A_R, Inv_A_G, Inv_A_B;
  logic            A_valid, ALE_done, overrun;

  ale_frame_engine #(
    .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN_PIX(WP), .INV_W(INVW), .SMOOTH_SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .input_window(input_window),
    .A_R(A_R), .A_G(A_G), .A_B(A_B),
    .Inv_A_R(Inv_A_R), .Inv_A_G(Inv_A_G), .Inv_A_B(Inv_A_B),
    .A_valid(A_valid), .ALE_done(ALE_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0][DW-1:0]   a;
    logic [2:0][INVW-1:0] inv;
    logic [31:0]          t;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: index 2=R, 1=G, 0=B.
  int m_cnt, m_best_dark, m_last_acc;
  int m_best[3];
  int m_pub[3];
  bit m_first, m_valid, m_ovr;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int floor_div(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int recip(input int a);
    int q;
    if (a == 0) return SAT;
    q = (1 << INVW) / a;
    return (q > SAT) ? SAT : q;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_best_dark = 0; m_last_acc = -1000;
    m_first = 1; m_valid = 0; m_ovr = 0;
    for (int c = 0; c < 3; c++) begin m_best[c] = 0; m_pub[c] = 0; end
    exp_q.delete();
  endtask

  task automatic model_frame_end(input int t);
    exp_t e;
    int an;
    if (t - m_last_acc < BUSY) begin
      m_ovr = 1;
      return;
    end
    m_last_acc = t;
    for (int c = 0; c < 3; c++) begin
      an = m_valid ? m_pub[c] + floor_div(m_best[c] - m_pub[c], 1 << SH) : m_best[c];
      m_pub[c]  = an;
      e.a[c]    = DW'(an);
      e.inv[c]  = INVW'(recip(an));
    end
    e.t = 32'(t + BUSY);
    m_valid = 1;
    exp_q.push_back(e);
  endtask

  task automatic model_sample(input logic [WB-1:0] w, input int t);
    int mn[3];
    int d, px;
    for (int c = 0; c < 3; c++) mn[c] = (1 << DW) - 1;
    for (int k = 0; k < WP; k++)
      for (int c = 0; c < 3; c++) begin
        px = int'(w[k*3*DW + c*DW +: DW]);
        if (px < mn[c]) mn[c] = px;
      end
    d = mn[0];
    if (mn[1] < d) d = mn[1];
    if (mn[2] < d) d = mn[2];
    if (m_first || d > m_best_dark) begin
      m_best_dark = d;
      for (int c = 0; c < 3; c++) m_best[c] = mn[c];
    end
    m_first = 0;
    m_cnt++;
    if (m_cnt == NPIX) begin
      m_cnt = 0;
      m_first = 1;
      model_frame_end(t);
    end
  endtask

  task automatic drive(input bit v, input logic [WB-1:0] w);
    @(posedge clk); #1;
    input_valid  = v;
    input_window = w;
    if (v) model_sample(w, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0);
  endtask

  function automatic logic [WB-1:0] uni(input int r, input int g, input int b);
    logic [WB-1:0] w;
    for (int k = 0; k < WP; k++) w[k*3*DW +: 3*DW] = {DW'(r), DW'(g), DW'(b)};
    return w;
  endfunction

  function automatic logic [WB-1:0] rnd_win(input int lo, input int hi);
    logic [WB-1:0] w;
    for (int i = 0; i < WP*3; i++) w[i*DW +: DW] = DW'($urandom_range(hi, lo));
    return w;
  endfunction

  task automatic send_uniform(input int r, input int g, input int b);
    repeat (NPIX) drive(1'b1, uni(r, g, b));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; input_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_A_R"}, A_R, 0);       chk({tag, "_A_G"}, A_G, 0);
    chk({tag, "_A_B"}, A_B, 0);       chk({tag, "_Inv_R"}, Inv_A_R, 0);
    chk({tag, "_Inv_G"}, Inv_A_G, 0); chk({tag, "_Inv_B"}, Inv_A_B, 0);
    chk({tag, "_A_valid"}, A_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_ALE_done"}, ALE_done, 0);
  endtask

  // Monitor: every ALE_done pulse must match the oldest expected publication.
  always @(negedge clk) begin
    if (!rst && ALE_done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ALE_done: pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pub_A_R", A_R, mon_e.a[2]);
        chk("pub_A_G", A_G, mon_e.a[1]);
        chk("pub_A_B", A_B, mon_e.a[0]);
        chk("pub_Inv_R", Inv_A_R, mon_e.inv[2]);
        chk("pub_Inv_G", Inv_A_G, mon_e.inv[1]);
        chk("pub_Inv_B", Inv_A_B, mon_e.inv[0]);
        chk("pub_cycle", cyc, int'(mon_e.t));
        chk("pub_A_valid", A_valid, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; input_valid = 1'b0; input_window = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("reset");

    // Uniform first frame, then a darker-red frame smoothed against it.
    send_uniform(200, 150, 100);
    idle(30);
    chk("t1_A_R", A_R, 200); chk("t1_A_G", A_G, 150); chk("t1_A_B", A_B, 100);
    chk("t1_Inv_R", Inv_A_R, 327); chk("t1_Inv_G", Inv_A_G, 436); chk("t1_Inv_B", Inv_A_B, 655);
    chk("t1_A_valid", A_valid, 1);
    send_uniform(100, 150, 100);
    idle(30);
    chk("t2_A_R", A_R, 175); chk("t2_Inv_R", Inv_A_R, 374);

    // Equal dark values: the first brightest pixel wins.
    do_reset();
    for (int p = 0; p < NPIX; p++)
      drive(1'b1, (p == 3) ? uni(200, 120, 130) : (p == 9) ? uni(180, 125, 120) : uni(60, 50, 40));
    idle(30);
    chk("tie_A_R", A_R, 200); chk("tie_A_G", A_G, 120); chk("tie_A_B", A_B, 130);

    // Reciprocal saturation at A=0 and A=1.
    do_reset();
    send_uniform(0, 0, 0);
    idle(30);
    chk("zero_A_R", A_R, 0); chk("zero_Inv_R", Inv_A_R, SAT); chk("zero_A_valid", A_valid, 1);
    do_reset();
    send_uniform(1, 1, 1);
    idle(30);
    chk("one_A_R", A_R, 1); chk("one_Inv_B", Inv_A_B, SAT);

    // Back-to-back short frames: every other frame end lands while busy.
    do_reset();
    for (int f = 0; f < 10; f++) send_uniform(30 + 20*f, 25 + 20*f, 20 + 20*f);
    idle(30);
    chk("ovr_set", overrun, 1);
    chk("ovr_model", overrun, int'(m_ovr));

    // Reset in the middle of the divide aborts the result and clears stickies.
    send_uniform(90, 80, 70);
    idle(8);
    do_reset();
    check_cleared("midrst");
    idle(30);
    send_uniform(40, 30, 20);
    idle(30);
    chk("post_rst_A_R", A_R, 40); chk("post_rst_A_G", A_G, 30); chk("post_rst_A_B", A_B, 20);

    // Randomized frames with bubbles and variable inter-frame gaps.
    do_reset();
    for (int f = 0; f < 12; f++) begin
      for (int p = 0; p < NPIX; p++) begin
        if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
        if ($urandom_range(7, 0) == 0) drive(1'b1, rnd_win(0, 255));
        else drive(1'b1, rnd_win(100, 115));
      end
      idle($urandom_range(24, 0));
    end
    idle(30);
    chk("rnd_overrun", overrun, int'(m_ovr));
    chk("rnd_A_valid", A_valid, int'(m_valid));
    chk("pending_results", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
